// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: state encoding and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_DATA_WIDTH = 32;

  // Transfer state encoding, kept as plain constants so older blocks can reuse it.
  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;
  localparam apb_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY and flags the cycle on which
// the transfer has to be abandoned. A TIMEOUT of 0 means wait forever.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] SAT  = CW'((TIMEOUT > 0) ? TIMEOUT : (2 ** CW) - 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  // Saturating wait counter, restarted whenever a new ACCESS phase begins.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + CW'(1);
    end
  end

  // Fires while waiting when this increment would bring the count to TIMEOUT,
  // so the abort happens after exactly TIMEOUT stalled ACCESS cycles.
  assign expired = (TIMEOUT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: takes one command, runs SETUP/ACCESS on the
// bus, and holds the response until the requester consumes it.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  apb_state_t state;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_expired;

  // Commands are only taken when nothing is in flight.
  assign cmd_ready = (state == ST_IDLE);

  // The counter restarts in SETUP so every ACCESS phase sees a fresh budget.
  assign timer_clear  = (state == ST_SETUP);
  assign timer_enable = (state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Transfer sequencer; all bus and response outputs are registered here.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state     <= ST_RESP;
          end else if (timer_expired) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a memory-backed slave with configurable
// wait states, and a transaction-level model of the expected outcome.
module tb_apb_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  // Contents of the slave as the requester should see them.
  logic [DW-1:0] mem [logic [AW-1:0]];

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // One complete transfer. Called on a falling edge with the master idle.
  // waits = ACCESS cycles the slave holds PREADY low, rdelay = cycles of
  // response back-pressure, noise = keep cmd_valid high with junk after accept.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input int rdelay, input logic noise);
    logic          exp_err;
    int            exp_access;
    int            seen;
    logic [DW-1:0] exp_rdata;
    logic [AW+DW:0] exp_bus;
    exp_err    = (waits >= TO);
    exp_access = exp_err ? TO : waits + 1;
    exp_rdata  = (wr || exp_err) ? '0 : mem_rd(addr);
    exp_bus    = {wr, addr, wdata};

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge PCLK);
    if (noise) begin
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end

    checks++;
    if ({PSEL, PENABLE, cmd_ready} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL setup_ctrl got %b exp 100", {PSEL, PENABLE, cmd_ready});
    end
    checks++;
    if ({PWRITE, PADDR, PWDATA} !== exp_bus) begin
      errors++;
      $display("[TB] FAIL setup_bus got %h exp %h", {PWRITE, PADDR, PWDATA}, exp_bus);
    end

    seen = 0;
    @(negedge PCLK);
    while (PSEL && PENABLE && (seen <= TO + 4)) begin
      checks++;
      if ({PWRITE, PADDR, PWDATA, cmd_ready} !== {exp_bus, 1'b0}) begin
        errors++;
        $display("[TB] FAIL access_hold got %h exp %h", {PWRITE, PADDR, PWDATA, cmd_ready}, {exp_bus, 1'b0});
      end
      PREADY = (seen == waits);
      if (PREADY && !wr) PRDATA = mem_rd(addr);
      else if ($urandom_range(0, 1) == 1) PRDATA = 'z;
      else PRDATA = DW'($urandom);
      seen++;
      @(negedge PCLK);
    end
    PREADY = 1'b0;
    PRDATA = 'z;

    checks++;
    if (seen != exp_access) begin
      errors++;
      $display("[TB] FAIL access_len got %0d exp %0d", seen, exp_access);
    end
    checks++;
    if ({rsp_valid, PSEL, PENABLE, cmd_ready} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL resp_ctrl got %b exp 1000", {rsp_valid, PSEL, PENABLE, cmd_ready});
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== {exp_err, exp_rdata}) begin
      errors++;
      $display("[TB] FAIL resp_data got %h exp %h", {rsp_err, rsp_rdata}, {exp_err, exp_rdata});
    end

    repeat (rdelay) begin
      @(negedge PCLK);
      checks++;
      if ({rsp_valid, cmd_ready, PSEL, rsp_err, rsp_rdata} !== {3'b100, exp_err, exp_rdata}) begin
        errors++;
        $display("[TB] FAIL resp_hold got %h exp %h", {rsp_valid, cmd_ready, PSEL, rsp_err, rsp_rdata},
                 {3'b100, exp_err, exp_rdata});
      end
    end

    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL resp_done got %b exp 010", {rsp_valid, cmd_ready, PSEL});
    end

    if (wr && !exp_err) mem[addr] = wdata;
  endtask

  task automatic test_reset();
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = 'z;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h exp 0",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata});
    end
    PRESETn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b exp 1", cmd_ready);
    end
    @(negedge PCLK);
  endtask

  task automatic test_write_read();
    run_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 0, 0, 1'b0);
    run_xfer(1'b0, 16'h0010, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_xfer(1'b0, 16'h0010, 32'h0, 3, 0, 1'b0);
    run_xfer(1'b1, 16'h0020, 32'h12345678, TO - 1, 1, 1'b0);
    run_xfer(1'b0, 16'h0020, 32'h0, TO - 1, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 16'h0010, 32'h0, TO, 0, 1'b0);
    run_xfer(1'b1, 16'h0010, 32'hCAFEF00D, 100, 2, 1'b0);
    run_xfer(1'b0, 16'h0010, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_back_pressure();
    run_xfer(1'b0, 16'h0010, 32'h0, 0, 5, 1'b1);
    run_xfer(1'b1, 16'h0030, 32'h0BADCAFE, 2, 5, 1'b1);
  endtask

  task automatic test_random();
    logic          wr;
    logic [AW-1:0] addr;
    int            waits;
    for (int i = 0; i < 40; i++) begin
      wr    = 1'($urandom);
      addr  = AW'(16'h0100 + 4 * $urandom_range(0, 7));
      waits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                          : int'($urandom_range(0, 3));
      run_xfer(wr, addr, DW'($urandom), waits, int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0040;
    cmd_wdata = 32'h55AA55AA;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL mid_in_access got %b exp 11", {PSEL, PENABLE});
    end
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_reset_drop got %b exp 000", {PSEL, PENABLE, rsp_valid});
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_release_ready got %b exp 1", cmd_ready);
    end
    repeat (4) begin
      @(negedge PCLK);
      checks++;
      if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL mid_no_resp got %b exp 001", {rsp_valid, PSEL, cmd_ready});
      end
    end
    run_xfer(1'b0, 16'h0040, 32'h0, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_back_pressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
